// File: rtl/led_scan_pkg.sv
// Shared widths, select-code limits, FSM encoding and the step helper for the LED scan controller.
package led_scan_pkg;

  localparam int SEL_W = 3;
  localparam logic [SEL_W-1:0] SEL_MAX = 3'd7;
  localparam logic [SEL_W-1:0] SEL_MIN = 3'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  // One step of the select code; the 3-bit arithmetic gives the 7->0 / 0->7 wrap.
  function automatic logic [SEL_W-1:0] sel_step(input logic [SEL_W-1:0] cur, input logic down);
    return down ? (cur - 1'b1) : (cur + 1'b1);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Raw active-low key -> 2-FF synchroniser -> debounced level -> one-cycle press pulse on 1->0.
module key_debounce
  import led_scan_pkg::*;
#(
  parameter int DB_CNT_MAX = 999_999
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_n,
  output logic press
);

  localparam int CW = (DB_CNT_MAX > 0) ? $clog2(DB_CNT_MAX + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CNT_MAX);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          level_reg;
  logic          press_reg;
  logic [CW-1:0] cnt_reg;

  // The counter only advances while the synchronised level differs from the accepted one,
  // so any bounce back to the accepted level restarts the stable-time measurement.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      level_reg <= 1'b1;
      press_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= key_n;
      sync2_reg <= sync1_reg;
      press_reg <= 1'b0;
      if (sync2_reg == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        cnt_reg   <= '0;
        level_reg <= sync2_reg;
        press_reg <= ~sync2_reg;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign press = press_reg;

endmodule

// File: rtl/led_scan_ctrl.sv
// Select-code generator for a 3-to-8 decoder with start/pause/stop keys.
// Define LED_SCAN_BOUNCE_EN for ping-pong scanning instead of wrap-around.
module led_scan_ctrl
  import led_scan_pkg::*;
#(
  parameter int STEP_CNT_MAX = 24_999_999,
  parameter int DB_CNT_MAX   = 999_999
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             key_start_n,
  input  logic             key_stop_n,
  input  logic             dir,
  output logic [SEL_W-1:0] sel,
  output logic             step_pulse,
  output logic             running
);

  localparam int SW = (STEP_CNT_MAX > 0) ? $clog2(STEP_CNT_MAX + 1) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CNT_MAX);

  state_t           state_reg, state_next;
  logic [SW-1:0]    step_cnt_reg, step_cnt_next;
  logic [SEL_W-1:0] sel_reg, sel_next;
  logic             pulse_reg, pulse_next;
  logic             running_reg, running_next;
  logic             start_press, stop_press;
`ifdef LED_SCAN_BOUNCE_EN
  logic             down_reg, down_next;
  logic             turn;
`endif

  key_debounce #(.DB_CNT_MAX(DB_CNT_MAX)) u_start_key (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key_n     (key_start_n),
    .press     (start_press)
  );

  key_debounce #(.DB_CNT_MAX(DB_CNT_MAX)) u_stop_key (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key_n     (key_stop_n),
    .press     (stop_press)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg    <= ST_IDLE;
      step_cnt_reg <= '0;
      sel_reg      <= SEL_MIN;
      pulse_reg    <= 1'b0;
      running_reg  <= 1'b0;
`ifdef LED_SCAN_BOUNCE_EN
      down_reg     <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      step_cnt_reg <= step_cnt_next;
      sel_reg      <= sel_next;
      pulse_reg    <= pulse_next;
      running_reg  <= running_next;
`ifdef LED_SCAN_BOUNCE_EN
      down_reg     <= down_next;
`endif
    end
  end

  // Stop is checked first so a simultaneous start/stop always behaves as a stop.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start_press && !stop_press) state_next = ST_RUN;
      ST_RUN:   if (stop_press) state_next = ST_PAUSE;
      ST_PAUSE: begin
        if (stop_press)       state_next = ST_IDLE;
        else if (start_press) state_next = ST_RUN;
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    step_cnt_next = step_cnt_reg;
    sel_next      = sel_reg;
    pulse_next    = 1'b0;
    running_next  = (state_next == ST_RUN);
`ifdef LED_SCAN_BOUNCE_EN
    down_next     = down_reg;
    turn          = down_reg ? (sel_reg == SEL_MIN) : (sel_reg == SEL_MAX);
`endif
    if (state_reg == ST_RUN) begin
      if (step_cnt_reg == STEP_LAST) begin
        step_cnt_next = '0;
        pulse_next    = 1'b1;
`ifdef LED_SCAN_BOUNCE_EN
        down_next     = down_reg ^ turn;
        sel_next      = sel_step(sel_reg, down_reg ^ turn);
`else
        sel_next      = sel_step(sel_reg, dir);
`endif
      end else begin
        step_cnt_next = step_cnt_reg + 1'b1;
      end
    end else if (state_next == ST_IDLE) begin
      step_cnt_next = '0;
      sel_next      = SEL_MIN;
    end
`ifdef LED_SCAN_BOUNCE_EN
    if (state_reg == ST_IDLE && state_next == ST_RUN) down_next = dir;
`endif
  end

  assign sel        = sel_reg;
  assign step_pulse = pulse_reg;
  assign running    = running_reg;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Directed, table-driven bench for led_scan_ctrl with STEP_CNT_MAX=3 and DB_CNT_MAX=4.
module tb_led_scan_ctrl;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       key_start_n = 1'b1;
  logic       key_stop_n = 1'b1;
  logic       dir = 1'b0;
  logic [2:0] sel;
  logic       step_pulse;
  logic       running;

  led_scan_ctrl #(.STEP_CNT_MAX(3), .DB_CNT_MAX(4)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .key_start_n (key_start_n),
    .key_stop_n  (key_stop_n),
    .dir         (dir),
    .sel         (sel),
    .step_pulse  (step_pulse),
    .running     (running)
  );

  always #5 sys_clk = ~sys_clk;

  // Key driver: a key held low for N clocks, changed 2 time units after a rising edge.
  int start_len = 0;
  int stop_len  = 0;
  always @(posedge sys_clk) begin
    #2;
    if (start_len > 0) begin key_start_n = 1'b0; start_len--; end
    else key_start_n = 1'b1;
    if (stop_len > 0) begin key_stop_n = 1'b0; stop_len--; end
    else key_stop_n = 1'b1;
  end

  typedef enum int {OP_DIR, OP_START, OP_STEP, OP_STOPA, OP_BOTHA, OP_PAUSE, OP_STOP, OP_GLITCH} op_t;
  typedef struct {
    op_t op;
    int  arg;   // key length, gap, hold cycles, or idle flag depending on op
    int  exp;   // expected sel or expected running
  } vec_t;
  vec_t tbl[$];

  int checks = 0;
  int errors = 0;
  int run_cnt = 0;
  int gap_last = 0;
  int unstable = 0;
  int dbl = 0;
  logic [2:0] last_sel = 3'd0;
  logic prev_pulse = 1'b0;

  function automatic void add(op_t op, int arg, int exp);
    vec_t v;
    v.op = op; v.arg = arg; v.exp = exp;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // One clock; tracks running cycles between steps, sel changes without a pulse, long pulses.
  task automatic tick();
    @(negedge sys_clk);
    if (running) run_cnt++;
    if (step_pulse) begin
      if (prev_pulse) dbl++;
      gap_last = run_cnt;
      run_cnt  = 0;
      last_sel = sel;
    end else if (sel != last_sel) begin
      if (sel == 3'd0 && !running) last_sel = sel;
      else unstable++;
    end
    prev_pulse = step_pulse;
  endtask

  task automatic wait_level(input logic exp, input int bound, input string name);
    int n = 0;
    while (running !== exp && n < bound) begin tick(); n++; end
    chk(name, int'(running), int'(exp));
  endtask

  task automatic wait_step(input int exp_sel, input int exp_gap);
    int n = 0;
    do begin tick(); n++; end while (!step_pulse && n < 40);
    chk($sformatf("step to %0d pulse seen", exp_sel), int'(step_pulse), 1);
    chk($sformatf("step to %0d sel", exp_sel), int'(sel), exp_sel);
    chk($sformatf("step to %0d running cycles", exp_sel), gap_last, exp_gap);
  endtask

  task automatic hold(input int n, input int exp_sel, input string name);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (int'(sel) != exp_sel || running || step_pulse) bad++;
    end
    chk(name, bad, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    logic [2:0] t2 [8];
    logic [2:0] t4 [6];
    logic [2:0] t5 [5];
`ifdef LED_SCAN_BOUNCE_EN
    t2 = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6};
    t4 = '{3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    t5 = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
`else
    t2 = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    t4 = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
    t5 = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3};
`endif
    // Scan up from IDLE, first step needs one extra running cycle.
    add(OP_DIR, 0, 0);
    add(OP_START, 10, 0);
    for (int k = 0; k < 8; k++) add(OP_STEP, (k == 0) ? 5 : 4, int'(t2[k]));
    // Pause mid-scan, resume, then stop twice.
    for (int k = 0; k < 3; k++) add(OP_STEP, 4, int'(t4[k]));
    add(OP_STOPA, 10, 0);
    add(OP_STEP, 4, int'(t4[3]));
    add(OP_STEP, 4, int'(t4[4]));
    add(OP_PAUSE, 40, int'(t4[4]));
    add(OP_START, 10, 0);
    add(OP_STEP, 4, int'(t4[5]));
    add(OP_STOP, 0, 0);
    add(OP_STOP, 1, 0);
    // Short key glitches are rejected; DB_CNT_MAX+1 low cycles are accepted.
    for (int len = 1; len <= 5; len++) add(OP_GLITCH, len, (len == 5) ? 1 : 0);
    add(OP_STOP, 0, 0);
    add(OP_STOP, 1, 0);
    // Count down, then simultaneous start+stop pauses.
    add(OP_DIR, 1, 0);
    add(OP_START, 10, 0);
    add(OP_STEP, 5, int'(t5[0]));
    add(OP_STEP, 4, int'(t5[1]));
    add(OP_STEP, 4, int'(t5[2]));
    add(OP_BOTHA, 10, 0);
    add(OP_STEP, 4, int'(t5[3]));
    add(OP_STEP, 4, int'(t5[4]));
    add(OP_PAUSE, 20, int'(t5[4]));
    add(OP_STOP, 1, 0);

    // Reset state.
    repeat (3) @(negedge sys_clk);
    chk("in reset sel", int'(sel), 0);
    chk("in reset running", int'(running), 0);
    sys_rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("idle cycle %0d {sel,pulse,running}", i), int'({sel, step_pulse, running}), 0);
    end

    for (int i = 0; i < tbl.size(); i++) begin
      vec_t v;
      v = tbl[i];
      case (v.op)
        OP_DIR:    begin dir = v.arg[0]; tick(); end
        OP_START:  begin start_len = v.arg; wait_level(1'b1, 30, $sformatf("vec %0d start running", i)); end
        OP_STEP:   wait_step(v.exp, v.arg);
        OP_STOPA:  stop_len = v.arg;
        OP_BOTHA:  begin start_len = v.arg; stop_len = v.arg; end
        OP_PAUSE:  begin
          wait_level(1'b0, 20, $sformatf("vec %0d pause running", i));
          chk($sformatf("vec %0d paused sel", i), int'(sel), v.exp);
          hold(v.arg, v.exp, $sformatf("vec %0d pause hold violations", i));
        end
        OP_STOP:   begin
          stop_len = 10;
          repeat (20) tick();
          chk($sformatf("vec %0d stop running", i), int'(running), 0);
          if (v.arg != 0) begin
            chk($sformatf("vec %0d idle sel", i), int'(sel), 0);
            hold(10, 0, $sformatf("vec %0d idle hold violations", i));
            run_cnt = 0;
          end
        end
        OP_GLITCH: begin
          start_len = v.arg;
          repeat (15) tick();
          chk($sformatf("glitch %0d cycles running", v.arg), int'(running), v.exp);
        end
        default:   tick();
      endcase
    end

    // Asynchronous reset in the middle of RUN.
    dir = 1'b0;
    start_len = 10;
    wait_level(1'b1, 30, "pre-reset start running");
    wait_step(1, 5);
    wait_step(2, 4);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("async reset sel", int'(sel), 0);
    chk("async reset running", int'(running), 0);
    chk("async reset step_pulse", int'(step_pulse), 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    run_cnt = 0;
    last_sel = 3'd0;
    hold(5, 0, "after reset hold violations");

    chk("sel changes without step_pulse", unstable, 0);
    chk("step_pulse longer than one cycle", dbl, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
